instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage for the MIPS core: owns the PC, issues one word-aligned read at a time to instruction memory, and holds each returned word for the downstream decoder until it is consumed. Redirects (taken branch, J/JAL/JR target) come back from the execute/branch logic. In-flight fetches on the wrong path are squashed. Sits directly upstream of `decoder`: `out_instr` drives its `raw_instr`.

## Interface
- `RESET_PC`, default 32'hbfc0_0000: PC loaded on reset.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `ireq_valid`  out  1  fetch request to instruction memory.
- `ireq_addr`  out  32  request address, equal to the current PC.
- `ireq_ready`  in  1  memory accepts the request this cycle.
- `iresp_valid`  in  1  read data valid; at most one response per accepted request, in order.
- `iresp_data`  in  32  instruction word.
- `redirect_valid`  in  1  PC redirect this cycle.
- `redirect_pc`  in  32  new PC.
- `out_valid`  out  1  held instruction valid to the decoder.
- `out_ready`  in  1  decoder/consumer accepts it.
- `out_instr`  out  32  instruction word (`word_t`).
- `out_pc`  out  32  PC of `out_instr`.
- `out_pcplus4`  out  32  `out_pc + 4`, mod 2^32 (JAL link value).
- `out_adel`  out  1  fetch address error (PC[1:0] != 0); `out_instr` = 0 when set.

## Operation
- Registers: `pc`, `state` ∈ {REQ, WAIT, HOLD}, `drop` flag, `instr_q`, `adel_q`.
- REQ:
  - PC aligned: `ireq_valid` = 1 and `ireq_addr` = `pc`. On `ireq_ready`, go to WAIT.
  - PC misaligned: no request. Next cycle go to HOLD with `adel_q` = 1 and `instr_q` = 0.
- WAIT:
  - On `iresp_valid` with `drop` = 0: capture `instr_q` ← `iresp_data` and go to HOLD.
  - On `iresp_valid` with `drop` = 1: discard the data, clear `drop`, go to REQ.
- HOLD:
  - `out_valid` = 1.
  - On `out_ready`: `pc` ← `pc + 4` (wraps), clear `adel_q`, go to REQ.
- Redirect has the highest priority in every state and sets `pc` ← `redirect_pc`:
  - REQ without acceptance: stay in REQ. The new address is presented next cycle.
  - REQ with `ireq_ready` in the same cycle: go to WAIT with `drop` = 1, because the old-path request is in flight.
  - WAIT without `iresp_valid`: set `drop` = 1.
  - WAIT with `iresp_valid` in the same cycle: discard the data, go to REQ, `drop` = 0.
  - HOLD: discard `instr_q`, clear `adel_q`, go to REQ. If `out_ready` is also high, the instruction counts as consumed, but `pc` takes `redirect_pc`, not `pc + 4`.
- `iresp_valid` in REQ or HOLD is a protocol violation. It is ignored and flagged by assertion.
- `out_pc` = `pc` whenever `out_valid` = 1.

## Timing
- Reset values:
  - Registers: `pc` = `RESET_PC`, state REQ, `drop` = 0, `instr_q` = 0, `adel_q` = 0.
  - Outputs: `out_valid` = 0, `out_instr` = 0, `out_pc` = `RESET_PC`, `out_adel` = 0, `ireq_valid` = 0 while `reset` is high.
- First request: `ireq_valid` rises in the first cycle after reset deasserts.
- Reset mid-fetch: state is abandoned immediately. Instruction memory shares `reset`, so no stale response survives.
- Latency and throughput:
  - With zero-wait memory (ready and response in the next cycle), `out_valid` is asserted 2 cycles after the request cycle.
  - Throughput is at most 1 instruction per 3 cycles. There is no prefetch.
- Output registering:
  - `out_*` come from registers; no combinational path from `iresp_data` to `out_instr`.
  - `ireq_valid` and `ireq_addr` depend only on `state` and `pc`.
- Handshake rule: `out_valid` may not drop without `out_ready` except on redirect or reset. `out_instr` is stable while held.

## Structure
- Add to the shared `mips.svh` package: `fetch_state_t` enum (REQ/WAIT/HOLD) and the `RESET_PC_DEFAULT` constant. `word_t` is already defined there.
- One natural sub-module, `pc_reg`:
  - Holds `pc` and applies async reset to `RESET_PC`.
  - Load priority: redirect > `pc + 4` > hold.
- The FSM, drop flag and output buffer live in `instr_fetch`.

## Test plan
- Reset release with zero-wait memory, `out_ready` = 1: requests go to bfc00000, bfc00004, bfc00008. The first `out_valid` has `out_pc` = bfc00000 and `out_pcplus4` = bfc00004.
- Memory returns 0x24080005 and `out_ready` is held low for 5 cycles: `out_valid` and `out_instr` stay stable, no new `ireq_valid` is issued, and `pc` stays unchanged.
- Redirect to 0x80001000 in WAIT, then the response arrives: the data is dropped, the next request is at 0x80001000, and no `out_valid` is raised for the old word.
- Redirect to 0x80002000 in HOLD together with `out_ready`: the next request is at 0x80002000, not `pc + 4`.
- Redirect to 0x80000002: no `ireq_valid`; HOLD with `out_adel` = 1, `out_instr` = 0, `out_pc` = 80000002.
- Assert `reset` during WAIT: all outputs return to reset values asynchronously, and the first request after release is at `RESET_PC`.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types for the fetch stage: instruction word, fetch FSM states and reset vector.
package instr_fetch_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t RESET_PC_DEFAULT = 32'hbfc0_0000;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    // Instruction fetches must be word aligned.
    function automatic logic is_misaligned(input word_t addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter register: async reset to RESET_PC, redirect beats sequential advance.
module instr_fetch_pc_reg
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        advance,
    output logic [31:0] pc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (advance) begin
            pc <= pc + 32'd4;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding instruction read, single-entry output buffer to the decoder,
// redirects squash wrong-path fetches via the drop flag.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        ireq_ready,
    input  logic        iresp_valid,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pcplus4,
    output logic        out_adel
);

    fetch_state_t state, state_nxt;
    logic         drop_q, drop_nxt;
    word_t        instr_q, instr_nxt;
    logic         adel_q, adel_nxt;
    logic         pc_advance;
    word_t        pc;
    logic         pc_misaligned;

    assign pc_misaligned = is_misaligned(pc);

    instr_fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect_valid),
        .redirect_pc (redirect_pc),
        .advance     (pc_advance),
        .pc          (pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus drop/buffer updates; redirect dominates in every state.
    always_comb begin
        state_nxt  = state;
        drop_nxt   = drop_q;
        instr_nxt  = instr_q;
        adel_nxt   = adel_q;
        pc_advance = 1'b0;
        unique case (state)
            REQ: begin
                if (pc_misaligned) begin
                    if (!redirect_valid) begin
                        state_nxt = HOLD;
                        adel_nxt  = 1'b1;
                        instr_nxt = '0;
                    end
                end else if (ireq_ready) begin
                    // A redirect here leaves the old-path read in flight.
                    state_nxt = WAIT;
                    drop_nxt  = redirect_valid;
                end
            end
            WAIT: begin
                if (iresp_valid) begin
                    if (redirect_valid || drop_q) begin
                        state_nxt = REQ;
                        drop_nxt  = 1'b0;
                    end else begin
                        state_nxt = HOLD;
                        instr_nxt = iresp_data;
                        adel_nxt  = 1'b0;
                    end
                end else if (redirect_valid) begin
                    drop_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    state_nxt = REQ;
                    instr_nxt = '0;
                    adel_nxt  = 1'b0;
                end else if (out_ready) begin
                    state_nxt  = REQ;
                    adel_nxt   = 1'b0;
                    pc_advance = 1'b1;
                end
            end
            default: begin
                state_nxt = REQ;
                drop_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_q  <= 1'b0;
            instr_q <= '0;
            adel_q  <= 1'b0;
        end else begin
            drop_q  <= drop_nxt;
            instr_q <= instr_nxt;
            adel_q  <= adel_nxt;
        end
    end

    // Outputs decode straight from registers; the request is masked while reset is held.
    always_comb begin
        ireq_valid  = (state == REQ) && !pc_misaligned && !reset;
        ireq_addr   = pc;
        out_valid   = (state == HOLD);
        out_instr   = instr_q;
        out_pc      = pc;
        out_pcplus4 = pc + 32'd4;
        out_adel    = adel_q;
    end

    a_resp_only_in_wait : assert property (
        @(posedge clk) disable iff (reset) iresp_valid |-> (state == WAIT)
    ) else $error("instr_fetch: iresp_valid while not waiting for a response");

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: random memory/consumer/redirect stimulus, expected
// instruction stream derived from a PC-sequence model and an address-hashed memory image.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'hbfc0_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        ireq_ready;
    logic        iresp_valid;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pcplus4;
    logic        out_adel;

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .ireq_ready     (ireq_ready),
        .iresp_valid    (iresp_valid),
        .iresp_data     (iresp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pcplus4    (out_pcplus4),
        .out_adel       (out_adel)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    // Knobs
    int p_ready = 100, max_lat = 0, p_oready = 100, p_redir = 0;
    bit misalign_ok = 0;
    bit zero_wait = 0;
    int force_mode = 0;
    logic [31:0] force_pc = '0;

    // Model state
    logic [31:0] exp_q[$];
    bit          mem_busy = 0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    int          req_cyc = 0;
    bit          hold_expected = 0;
    int          consumed = 0;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2408_0005 ^ ((a - RST_PC) * 32'h9e37_79b1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stimulus: memory model, consumer, redirects; updates the expected PC stream.
    always begin
        bit          busy_pre, resp_now, fire;
        logic [31:0] rpc, e;
        @(negedge clk);
        #1;
        if (reset) begin
            ireq_ready     = 1'b0;
            iresp_valid    = 1'b0;
            iresp_data     = '0;
            redirect_valid = 1'b0;
            redirect_pc    = '0;
            out_ready      = 1'b0;
            mem_busy       = 0;
            hold_expected  = 0;
            exp_q.delete();
            exp_q.push_back(RST_PC);
        end else begin
            busy_pre = mem_busy;
            resp_now = 0;
            iresp_valid = 1'b0;
            iresp_data  = $urandom;
            if (mem_busy) begin
                if (mem_cnt == 0) begin
                    iresp_valid = 1'b1;
                    iresp_data  = mem_word(mem_addr);
                    mem_busy    = 0;
                    resp_now    = 1;
                end else begin
                    mem_cnt--;
                end
            end
            if (ireq_valid) begin
                chk("req_aligned", 32'(ireq_addr[1:0]), 32'd0);
                chk("req_idle", 32'({out_valid, busy_pre}), 32'd0);
                if (exp_q.size() > 0) chk("req_addr", ireq_addr, exp_q[0]);
            end
            ireq_ready = ($urandom % 100) < p_ready;
            if (ireq_valid && ireq_ready) begin
                mem_busy = 1;
                mem_addr = ireq_addr;
                mem_cnt  = $urandom_range(0, max_lat);
                req_cyc  = cyc;
            end
            out_ready = ($urandom % 100) < p_oready;
            fire = 0;
            rpc  = $urandom;
            case (force_mode)
                1: fire = busy_pre && !resp_now && !out_valid;
                2: if (out_valid) begin fire = 1; out_ready = 1'b1; end
                3: fire = 1;
                default: fire = 0;
            endcase
            if (fire) begin
                rpc = force_pc;
                force_mode = 0;
            end else if (($urandom % 100) < p_redir) begin
                fire = 1;
                rpc  = 32'h8000_0000 | ($urandom & 32'h000f_fffc);
                if (misalign_ok && ($urandom % 8) == 0) rpc = rpc | 32'($urandom_range(1, 3));
            end
            redirect_valid = fire;
            redirect_pc    = rpc;
            if (fire) begin
                exp_q.delete();
                exp_q.push_back(rpc);
            end else if (out_valid && out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                exp_q.push_back(e + 32'd4);
                consumed++;
            end
            hold_expected = out_valid && !out_ready && !fire;
        end
    end

    // Monitor: every presented instruction must match the head of the expected stream.
    always @(negedge clk) begin
        static int  idle_cnt = 0;
        static bit  prev_valid = 0;
        logic [31:0] e;
        bit          mis;
        if (reset) begin
            idle_cnt   = 0;
            prev_valid = 0;
        end else begin
            if (hold_expected) chk("valid_held", 32'(out_valid), 32'd1);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("exp_available", 32'd0, 32'd1);
                end else begin
                    e   = exp_q[0];
                    mis = (e % 4) != 0;
                    chk("out_pc", out_pc, e);
                    chk("out_pcplus4", out_pcplus4, e + 32'd4);
                    chk("out_adel", 32'(out_adel), 32'(mis));
                    chk("out_instr", out_instr, mis ? 32'd0 : mem_word(e));
                end
                if (zero_wait && !prev_valid) chk("zero_wait_latency", 32'(cyc - req_cyc), 32'd2);
                idle_cnt = 0;
            end else begin
                idle_cnt++;
                if (idle_cnt > 200) begin
                    chk("progress_timeout", 32'd0, 32'd1);
                    idle_cnt = 0;
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(out_valid), 32'd1);
    endtask

    task automatic wait_fired(input string name);
        int n = 0;
        while (force_mode != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(force_mode), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_instr"}, out_instr, 32'd0);
        chk({tag, "_out_pc"}, out_pc, RST_PC);
        chk({tag, "_out_adel"}, 32'(out_adel), 32'd0);
        chk({tag, "_ireq_valid"}, 32'(ireq_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] pc0, instr0;
        int n;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #2 chk_reset_outputs("rst");

        // Zero-wait memory, always-ready consumer
        zero_wait = 1;
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("zero_wait_count", 32'(consumed >= 5), 32'd1);
        zero_wait = 0;

        // Consumer stall: buffer held, no new request
        p_oready = 0;
        wait_valid("stall_valid");
        pc0 = out_pc;
        instr0 = out_instr;
        repeat (5) @(negedge clk);
        chk("stall_valid_held", 32'(out_valid), 32'd1);
        chk("stall_pc", out_pc, pc0);
        chk("stall_instr", out_instr, instr0);
        chk("stall_no_req", 32'(ireq_valid), 32'd0);
        p_oready = 100;

        // Redirect while waiting for the response
        max_lat = 3;
        force_pc = 32'h8000_1000;
        force_mode = 1;
        wait_fired("redir_wait_fired");
        wait_valid("redir_wait_valid");
        chk("redir_wait_pc", out_pc, 32'h8000_1000);

        // Redirect in HOLD with out_ready
        force_pc = 32'h8000_2000;
        force_mode = 2;
        wait_fired("redir_hold_fired");
        wait_valid("redir_hold_valid");
        chk("redir_hold_pc", out_pc, 32'h8000_2000);

        // Misaligned redirect target
        force_pc = 32'h8000_0002;
        force_mode = 3;
        wait_fired("adel_fired");
        wait_valid("adel_valid");
        chk("adel_flag", 32'(out_adel), 32'd1);
        chk("adel_instr", out_instr, 32'd0);
        chk("adel_pc", out_pc, 32'h8000_0002);
        force_pc = 32'h8000_3000;
        force_mode = 2;
        wait_fired("adel_exit_fired");

        // Asynchronous reset while a read is outstanding
        n = 0;
        while (!(mem_busy && mem_cnt > 0 && !out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_wait_found", 32'(mem_busy && mem_cnt > 0), 32'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk_reset_outputs("rst_mid");
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        wait_valid("rst_after_valid");
        chk("rst_after_pc", out_pc, RST_PC);

        // Random traffic
        p_ready = 70;
        max_lat = 4;
        p_oready = 60;
        p_redir = 5;
        misalign_ok = 1;
        n = consumed;
        repeat (3000) @(negedge clk);
        chk("random_progress", 32'((consumed - n) > 50), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
